// File: rtl/mem_pkg.sv
// mem_pkg: shared store-size encodings, FSM states and latency counter width for mem_responder
package mem_pkg;
    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam int CNT_W = 4;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_READ     = 3'd2,
        ST_COMMIT   = 3'd3,
        ST_RMW_RD   = 3'd4,
        ST_RMW_WR   = 3'd5,
        ST_RESP_ERR = 3'd6
    } mem_state_e;
    // final action state of a legal request once its latency has elapsed
    function automatic mem_state_e op_target(input logic wr, input logic [1:0] sz);
        return !wr ? ST_READ : (sz == MEM_WORD) ? ST_COMMIT : ST_RMW_RD;
    endfunction
endpackage

// File: rtl/mem_byte_merge.sv
// mem_byte_merge: merges right-aligned store data into an old word by size and byte lane
module mem_byte_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);
    // word replaces everything; byte/half overwrite one little-endian lane, half ignores lane[0]
    always_comb begin
        merged = old_word;
        if (size == MEM_WORD) merged = wdata;
        else if (size == MEM_BYTE) merged[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (size == MEM_HALF) merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-organised memory responder with busy/done handshake and LAT-cycle latency; MEM_ERR_EN rejects misaligned accesses
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    mem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic wr_q, wr_d;
    logic [1:0] size_q, size_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;
    logic done_q, done_d, busy_q, busy_d, err_q, err_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] merged;
    logic illegal, mem_we, addr_unused;
    assign idx = addr_q[AW+1:2];
    assign addr_unused = ^addr[31:AW+2];
    assign mem_we = state_q == ST_COMMIT || state_q == ST_RMW_WR;
`ifdef MEM_ERR_EN
    assign illegal = (write && size == 2'b11) || ((!write || size == MEM_WORD) && addr[1:0] != 2'b00) || (write && size == MEM_HALF && addr[0]);
`else
    assign illegal = write && size == 2'b11;
`endif
    mem_byte_merge u_merge (
        .old_word (merge_q),
        .wdata    (wdata_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .merged   (merged)
    );
    // request latching, latency countdown and next-state selection
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        wr_d = wr_q;
        size_d = size_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: if (req) begin
                wr_d = write;
                size_d = size;
                addr_d = addr[AW+1:0];
                wdata_d = wdata;
                cnt_d = CNT_W'(LAT - 1);
                state_d = illegal ? ST_RESP_ERR : (LAT == 1) ? op_target(write, size) : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = op_target(wr_q, size_q);
            end
            ST_RMW_RD: state_d = ST_RMW_WR;
            default: state_d = ST_IDLE;
        endcase
    end
    // registered outputs follow the next state so rdata, done and err line up in the completion cycle
    always_comb begin
        rdata_d = state_d == ST_READ ? mem[addr_d[AW+1:2]] : rdata_q;
        merge_d = state_q == ST_RMW_RD ? mem[idx] : merge_q;
        done_d = state_d == ST_READ || state_d == ST_COMMIT || state_d == ST_RMW_WR || state_d == ST_RESP_ERR;
        err_d = state_d == ST_RESP_ERR;
        busy_d = state_d != ST_IDLE;
    end
    // control and output registers; reset abandons any in-flight store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            wr_q <= 1'b0;
            size_q <= MEM_WORD;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            wr_q <= wr_d;
            size_q <= size_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            done_q <= done_d;
            busy_q <= busy_d;
            err_q <= err_d;
        end
    end
    // storage array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= merged;
    end
    assign rdata = rdata_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a word-array reference model
module tb_mem_responder;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic reset_n, req, write;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata;
    logic done, busy, err;
    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [256];
    bit ref_valid [256];
    logic [31:0] exp_rd;
    bit rd_known;

    mem_responder #(.DEPTH_WORDS(256), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset_n),
        .req   (req),
        .write (write),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic txn(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n, lat, idx, sh;
        bit ill;
        ill = wr && sz == 2'b11;
`ifdef MEM_ERR_EN
        ill = ill || ((!wr || sz == 2'b00) && a[1:0] != 2'b00) || (wr && sz == 2'b10 && a[0]);
`endif
        lat = ill ? 1 : (wr && sz != 2'b00) ? LAT + 1 : LAT;
        idx = int'(a[9:2]);
        @(negedge clk);
        req = 1'b1; write = wr; size = sz; addr = a; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_after_accept", {31'b0, busy}, 32'd1);
        end while (!done && n < 40);
        req = 1'b0;
        check("latency", n, lat);
        check("err", {31'b0, err}, {31'b0, ill});
        if (!ill && wr) begin
            if (sz == 2'b00) begin
                ref_mem[idx] = d;
                ref_valid[idx] = 1'b1;
            end else if (sz == 2'b01) begin
                sh = 8 * int'(a[1:0]);
                ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
            end else begin
                sh = 16 * int'(a[1]);
                ref_mem[idx] = (ref_mem[idx] & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
            end
        end
        if (!ill && !wr) begin
            rd_known = ref_valid[idx];
            exp_rd = ref_mem[idx];
        end
        if (rd_known) check("rdata", rdata, exp_rd);
        @(negedge clk);
        check("done_one_pulse", {31'b0, done}, 32'd0);
        check("busy_released", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int first, second, n, dones;
        reset_n = 1'b0; req = 1'b0; write = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        exp_rd = '0; rd_known = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            ref_valid[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        reset_n = 1'b1;

        txn(1, 2'b00, 32'h10, 32'hDEADBEEF);
        txn(0, 2'b00, 32'h10, 32'h0);
        check("word_readback", rdata, 32'hDEADBEEF);

        txn(1, 2'b00, 32'h20, 32'h11223344);
        txn(1, 2'b01, 32'h22, 32'h000000AA);
        txn(0, 2'b00, 32'h20, 32'h0);
        check("byte_merge", rdata, 32'h11AA3344);

        txn(1, 2'b00, 32'h30, 32'h11223344);
        txn(1, 2'b10, 32'h32, 32'h0000BEEF);
        txn(0, 2'b00, 32'h30, 32'h0);
        check("half_merge", rdata, 32'hBEEF3344);

        txn(1, 2'b00, 32'h40, 32'hCAFEF00D);
        txn(0, 2'b00, 32'h41, 32'h0);
`ifdef MEM_ERR_EN
        check("misaligned_rdata_held", rdata, 32'hBEEF3344);
`else
        check("misaligned_load_aligned", rdata, 32'hCAFEF00D);
`endif

        txn(1, 2'b11, 32'h10, 32'h12345678);
        txn(0, 2'b00, 32'h10, 32'h0);
        check("reserved_size_no_write", rdata, 32'hDEADBEEF);

        @(negedge clk);
        req = 1'b1; write = 1'b0; size = 2'b00; addr = 32'h20;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (i == 2) check("busy_while_repulse", {31'b0, busy}, 32'd1);
            req = (i == 2);
        end
        check("ignored_req_single_done", dones, 1);
        check("ignored_req_rdata", rdata, 32'h11AA3344);

        @(negedge clk);
        req = 1'b1; write = 1'b0; size = 2'b00; addr = 32'h10;
        first = 0; second = 0; n = 0;
        while (second == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (done && first == 0) first = n;
            else if (done) second = n;
        end
        req = 1'b0;
        check("b2b_first_done", first, LAT);
        check("b2b_second_done", second, 2 * LAT + 1);
        exp_rd = 32'hDEADBEEF;
        @(negedge clk);

        txn(1, 2'b00, 32'h50, 32'h00000077);
        @(negedge clk);
        req = 1'b1; write = 1'b1; size = 2'b00; addr = 32'h50; wdata = 32'h5;
        @(negedge clk);
        req = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        check("async_reset_done", {31'b0, done}, 32'd0);
        check("async_reset_err", {31'b0, err}, 32'd0);
        check("async_reset_rdata", rdata, 32'd0);
        exp_rd = '0; rd_known = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        txn(0, 2'b00, 32'h50, 32'h0);
        check("dropped_store", rdata, 32'h00000077);

        for (int i = 0; i < 8; i++) txn(1, 2'b00, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 40; i++)
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
